uart_img_loader: RTL

//  Upstream feeder of the face-detect top: deserialises a raw 8N1 UART stream from the laptop

---
 rtl/uart_img_loader.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/uart_img_loader.sv
// 8N1 UART receiver feeding a row-major greyscale frame buffer.
// Pulses laptop_img_rdy on a complete frame, frame_err on abort.
module uart_img_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int IMG_WIDTH    = 320,
    parameter int IMG_HEIGHT   = 240,
    parameter int TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     rx,
    output logic [IMG_HEIGHT-1:0][IMG_WIDTH-1:0][7:0] laptop_img,
    output logic                                     laptop_img_rdy,
    output logic                                     busy,
    output logic                                     frame_err
);

    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int BW   = $clog2(CLKS_PER_BIT);
    localparam int TW   = $clog2(TIMEOUT_CLKS + 1);
    localparam int RW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int CW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    localparam logic [BW-1:0] HALF  = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] FULL  = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST  = IW'(NPIX - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [CW-1:0] CLAST = CW'(IMG_WIDTH - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {F_IDLE, F_RECV} f_state_t;

    logic      rx_meta_q, rx_meta_d;
    logic      rx_s_q, rx_s_d;
    rx_state_t rx_state_q, rx_state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_valid, stop_err;

    f_state_t  f_state_q, f_state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic busy_q, busy_d;
    logic rdy_q, rdy_d;
    logic err_q, err_d;
    logic abort;
    logic [IMG_HEIGHT-1:0][IMG_WIDTH-1:0][7:0] img_q, img_d;

    always_comb begin
        rx_meta_d  = rx;
        rx_s_d     = rx_meta_q;
        rx_state_d = rx_state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        stop_err   = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s_q) begin
                    rx_state_d = RX_START;
                    baud_d     = '0;
                end
            end
            RX_START: begin
                if (baud_q == HALF) begin
                    baud_d     = '0;
                    bit_d      = '0;
                    rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (baud_q == FULL) begin
                    baud_d  = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_q == 3'd7) rx_state_d = RX_STOP;
                    else bit_d = bit_q + 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            RX_STOP: begin
                // Return to idle at mid-stop so a back-to-back start edge is not missed
                if (baud_q == FULL) begin
                    baud_d     = '0;
                    byte_valid = rx_s_q;
                    stop_err   = !rx_s_q;
                    rx_state_d = RX_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        f_state_d = f_state_q;
        idx_d     = idx_q;
        row_d     = row_q;
        col_d     = col_q;
        tmo_d     = tmo_q;
        busy_d    = busy_q;
        rdy_d     = 1'b0;
        err_d     = 1'b0;
        img_d     = img_q;
        abort     = 1'b0;
        unique case (f_state_q)
            F_IDLE: abort = stop_err;
            F_RECV: abort = stop_err || (tmo_q == TLAST);
            default: abort = 1'b0;
        endcase
        if (byte_valid) begin
            img_d[row_q][col_q] = shift_q;
            tmo_d = '0;
            if (idx_q == LAST) begin
                rdy_d     = 1'b1;
                busy_d    = 1'b0;
                idx_d     = '0;
                row_d     = '0;
                col_d     = '0;
                f_state_d = F_IDLE;
            end else begin
                busy_d    = 1'b1;
                idx_d     = idx_q + 1'b1;
                f_state_d = F_RECV;
                if (col_q == CLAST) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end else if (abort) begin
            err_d     = 1'b1;
            busy_d    = 1'b0;
            idx_d     = '0;
            row_d     = '0;
            col_d     = '0;
            tmo_d     = '0;
            f_state_d = F_IDLE;
        end else if (f_state_q == F_RECV) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_state_q <= RX_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            f_state_q  <= F_IDLE;
            idx_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            tmo_q      <= '0;
            busy_q     <= 1'b0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
            img_q      <= '0;
        end else begin
            rx_meta_q  <= rx_meta_d;
            rx_s_q     <= rx_s_d;
            rx_state_q <= rx_state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            f_state_q  <= f_state_d;
            idx_q      <= idx_d;
            row_q      <= row_d;
            col_q      <= col_d;
            tmo_q      <= tmo_d;
            busy_q     <= busy_d;
            rdy_q      <= rdy_d;
            err_q      <= err_d;
            img_q      <= img_d;
        end
    end

    assign laptop_img     = img_q;
    assign laptop_img_rdy = rdy_q;
    assign busy           = busy_q;
    assign frame_err      = err_q;

endmodule
